// File: rtl/stream_mux_sliced_pkg.sv
// Shared types and the round-robin pick helper for the sliced stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  // The pick helper works on a fixed-size vector so it can serve any
  // channel count up to RR_MAX_N; callers zero-extend their valid vector.
  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First valid channel scanning ptr, ptr+1, ... modulo n.
  // ptr must already be below n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t res;
    int       k;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      k = int'(ptr) + i;
      if (k >= n) begin
        k = k - n;
      end else begin
        k = k;
      end
      if ((i < n) && !res.found && valid[k[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = k[RR_IDX_W-1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_mux_sliced_if.sv
// Handshake bundle between the packet sources, the multiplexer and the consumer.
interface stream_mux_sliced_if
  import stream_mux_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W    = 8
);
  localparam int SEL_W = $clog2(N_IN);

  mux_mode_e           mode;
  logic [SEL_W-1:0]    sel;
  logic [N_IN-1:0]     in_valid;
  logic [N_IN-1:0]     in_ready;
  logic [N_IN*W-1:0]   in_data;
  logic [N_IN-1:0]     in_last;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic                out_last;
  logic [SEL_W-1:0]    out_chan;

  // Source/consumer side: drives the inputs and the downstream ready.
  modport master (
    output mode, sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_chan
  );

  // Multiplexer side.
  modport slave (
    input  mode, sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_chan
  );

endinterface

// File: rtl/stream_mux_sliced_mux_slice.sv
// One narrow N:1 slice of the datapath; all slices share the same select.
module mux_slice #(
  parameter int N_IN    = 4,
  parameter int SLICE_W = 2,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_IN*SLICE_W-1:0] din,
  output logic [SLICE_W-1:0]      dout
);

  // AND-OR select: exactly one channel term survives for an in-range sel.
  always_comb begin
    dout = '0;
    for (int k = 0; k < N_IN; k++) begin
      dout = dout | (din[k*SLICE_W +: SLICE_W] & {SLICE_W{int'(sel) == k}});
    end
  end

endmodule

// File: rtl/stream_mux_sliced.sv
// N-input stream multiplexer with packet locking, explicit or round-robin
// selection, a sliced datapath and a single registered output stage.
module stream_mux_sliced
  import stream_mux_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int W       = 8,
  parameter int SLICE_W = 2
) (
  input logic                clk,
  input logic                rst_n,
  stream_mux_sliced_if.slave bus
);

  localparam int SEL_W   = $clog2(N_IN);
  localparam int N_POW   = 1 << SEL_W;
  localparam int N_SLICE = W / SLICE_W;

  if ((W % SLICE_W) != 0) begin : g_bad_width
    $error("stream_mux_sliced: W must be a multiple of SLICE_W");
  end
  if ((N_IN < 2) || (N_IN > RR_MAX_N)) begin : g_bad_n_in
    $error("stream_mux_sliced: N_IN out of supported range");
  end

  logic [N_POW-1:0] valid_pad_s;
  logic [N_POW-1:0] last_pad_s;
  logic [N_POW-1:0] ready_pad_s;
  rr_pick_t         rr_res_s;
  logic             grant_found_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic             load_en_s;
  logic             accept_s;
  logic             next_last_s;
  logic [SEL_W-1:0] rr_next_s;
  logic [W-1:0]     data_sel_s;

  logic             out_valid_r;
  logic [W-1:0]     out_data_r;
  logic             out_last_r;
  logic [SEL_W-1:0] out_chan_r;
  logic             lock_r;
  logic [SEL_W-1:0] lock_chan_r;
  logic [SEL_W-1:0] rr_ptr_r;

  // Padding to a power of two keeps every SEL_W-wide index in range.
  assign valid_pad_s = N_POW'(bus.in_valid);
  assign last_pad_s  = N_POW'(bus.in_last);

  // Grant selection: an open packet owns the output until its last beat.
  always_comb begin
    rr_res_s      = rr_pick(RR_MAX_N'(bus.in_valid), RR_IDX_W'(rr_ptr_r), N_IN);
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    if (lock_r) begin
      grant_found_s = valid_pad_s[lock_chan_r];
      grant_idx_s   = lock_chan_r;
    end else if (bus.mode == MODE_RR) begin
      grant_found_s = rr_res_s.found;
      grant_idx_s   = SEL_W'(rr_res_s.idx);
    end else begin
      if ((int'(bus.sel) < N_IN) && valid_pad_s[bus.sel]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = bus.sel;
      end else begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
      end
    end
  end

  // Handshake: only the granted channel sees ready, and never during reset.
  always_comb begin
    load_en_s   = !out_valid_r || bus.out_ready;
    ready_pad_s = '0;
    accept_s    = 1'b0;
    if (grant_found_s && rst_n) begin
      ready_pad_s[grant_idx_s] = load_en_s;
      accept_s                 = load_en_s;
    end else begin
      ready_pad_s = '0;
      accept_s    = 1'b0;
    end
  end

  assign next_last_s  = last_pad_s[grant_idx_s];
  assign rr_next_s    = (int'(grant_idx_s) == (N_IN - 1)) ? '0 : (grant_idx_s + 1'b1);
  assign bus.in_ready = N_IN'(ready_pad_s);

  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    logic [N_IN*SLICE_W-1:0] slice_in_s;
    for (genvar k = 0; k < N_IN; k++) begin : g_chan
      assign slice_in_s[k*SLICE_W +: SLICE_W] = bus.in_data[k*W + s*SLICE_W +: SLICE_W];
    end
    mux_slice #(
      .N_IN    (N_IN),
      .SLICE_W (SLICE_W),
      .SEL_W   (SEL_W)
    ) u_slice (
      .sel  (grant_idx_s),
      .din  (slice_in_s),
      .dout (data_sel_s[s*SLICE_W +: SLICE_W])
    );
  end

  // Output register: load on accept, drop valid once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_chan_r  <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= data_sel_s;
      out_last_r  <= next_last_s;
      out_chan_r  <= grant_idx_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Packet lock and round-robin pointer both move only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r      <= 1'b0;
      lock_chan_r <= '0;
      rr_ptr_r    <= '0;
    end else if (accept_s) begin
      if (next_last_s) begin
        lock_r <= 1'b0;
        if (bus.mode == MODE_RR) begin
          rr_ptr_r <= rr_next_s;
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else begin
        lock_r      <= 1'b1;
        lock_chan_r <= grant_idx_s;
      end
    end else begin
      lock_r <= lock_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_chan  = out_chan_r;

endmodule

// File: tb/tb_stream_mux_sliced.sv
// Scoreboard bench for stream_mux_sliced: per-channel source queues drive the
// inputs, expected output beats are queued from the test plan and compared
// whenever the DUT hands a beat downstream.
module tb_stream_mux_sliced;
  import stream_mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_sliced_if #(.N_IN(4), .W(8)) bus  ();
  stream_mux_sliced_if #(.N_IN(3), .W(8)) bus3 ();

  stream_mux_sliced #(.N_IN(4), .W(8), .SLICE_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  stream_mux_sliced #(.N_IN(3), .W(8), .SLICE_W(2)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] chan;
  } exp_t;

  beat_t src_mem [4][16];
  int    src_rd  [4];
  int    src_wr  [4];
  exp_t  exp_q   [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    r0;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      if (src_rd[k] < src_wr[k]) begin
        b = src_mem[k][src_rd[k]];
        bus.in_valid[k]       = 1'b1;
        bus.in_data[k*8 +: 8] = b.data;
        bus.in_last[k]        = b.last;
      end else begin
        bus.in_valid[k]       = 1'b0;
        bus.in_data[k*8 +: 8] = 8'h00;
        bus.in_last[k]        = 1'b0;
      end
    end
  endtask

  task automatic push_src(input int k, input logic [7:0] d, input logic l);
    src_mem[k][src_wr[k]] = '{data: d, last: l};
    src_wr[k]++;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input logic [1:0] c);
    exp_q.push_back('{data: d, last: l, chan: c});
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) begin
      src_rd[k] = 0;
      src_wr[k] = 0;
    end
  endtask

  // One clock: score the output beat and note handshakes at the negedge,
  // then advance the sources and redrive just after the posedge.
  task automatic step();
    logic [3:0] acc;
    exp_t       e;
    @(negedge clk);
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check_value("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_value("out_data", 32'(bus.out_data), 32'(e.data));
        check_value("out_last", 32'(bus.out_last), 32'(e.last));
        check_value("out_chan", 32'(bus.out_chan), 32'(e.chan));
      end
    end
    acc = bus.in_valid & bus.in_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (acc[k]) src_rd[k]++;
    end
    drive();
  endtask

  task automatic drain(input int max_cycles);
    int c = 0;
    while ((exp_q.size() != 0) && (c < max_cycles)) begin
      step();
      c++;
    end
    check_value("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mode      = MODE_RR;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0000;
    bus.in_data   = 32'h0;
    bus.in_last   = 4'b0000;
    bus3.mode      = MODE_SEL;
    bus3.sel       = 2'd3;
    bus3.in_valid  = 3'b111;
    bus3.in_data   = 24'h332211;
    bus3.in_last   = 3'b111;
    bus3.out_ready = 1'b1;
    clear_all();

    // Reset with every channel valid, then round-robin single-beat packets.
    rst_n = 1'b0;
    push_src(0, 8'h01, 1'b1);
    push_src(1, 8'h11, 1'b1);
    push_src(2, 8'h21, 1'b1);
    push_src(3, 8'h31, 1'b1);
    push_src(0, 8'h02, 1'b1);
    drive();
    repeat (2) @(posedge clk);
    #3;
    check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_value("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check_value("rst_out_chan",  32'(bus.out_chan),  32'd0);
    check_value("rst_out_data",  32'(bus.out_data),  32'd0);
    check_value("rst_out_last",  32'(bus.out_last),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    check_value("rr_first_grant", 32'(bus.in_ready), 32'h1);
    push_exp(8'h01, 1'b1, 2'd0);
    push_exp(8'h11, 1'b1, 2'd1);
    push_exp(8'h21, 1'b1, 2'd2);
    push_exp(8'h31, 1'b1, 2'd3);
    push_exp(8'h02, 1'b1, 2'd0);
    repeat (6) step();
    check_value("rr_full_rate", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Explicit select of channel 2.
    clear_all();
    bus.mode = MODE_SEL;
    bus.sel  = 2'd2;
    push_src(2, 8'hA5, 1'b1);
    drive();
    #2;
    check_value("sel_ready", 32'(bus.in_ready), 32'h4);
    push_exp(8'hA5, 1'b1, 2'd2);
    drain(10);

    // Packet lock on channel 1 while sel moves to 3 mid-packet.
    clear_all();
    bus.sel = 2'd1;
    push_src(1, 8'hB1, 1'b0);
    push_src(1, 8'hB2, 1'b0);
    push_src(1, 8'hB3, 1'b1);
    push_src(0, 8'h0C, 1'b1);
    push_src(3, 8'h3C, 1'b1);
    drive();
    #2;
    check_value("lock_first", 32'(bus.in_ready), 32'h2);
    push_exp(8'hB1, 1'b0, 2'd1);
    push_exp(8'hB2, 1'b0, 2'd1);
    push_exp(8'hB3, 1'b1, 2'd1);
    push_exp(8'h3C, 1'b1, 2'd3);
    r0 = src_rd[0];
    step();
    bus.sel = 2'd3;
    #2;
    check_value("lock_hold", 32'(bus.in_ready), 32'h2);
    drain(20);
    check_value("ch3_served", 32'(src_rd[3]), 32'(src_wr[3]));
    check_value("ch0_not_served", 32'(src_rd[0]), 32'(r0));

    // Backpressure: four stalled cycles, then resume without loss.
    clear_all();
    drive();
    bus.sel = 2'd0;
    push_src(0, 8'h50, 1'b1);
    push_src(0, 8'h51, 1'b1);
    push_src(0, 8'h52, 1'b1);
    push_src(0, 8'h53, 1'b1);
    push_exp(8'h50, 1'b1, 2'd0);
    push_exp(8'h51, 1'b1, 2'd0);
    push_exp(8'h52, 1'b1, 2'd0);
    push_exp(8'h53, 1'b1, 2'd0);
    drive();
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_value("bp_ready", 32'(bus.in_ready),  32'h0);
      check_value("bp_valid", 32'(bus.out_valid), 32'd1);
      check_value("bp_hold",  32'(bus.out_data),  32'h50);
    end
    bus.out_ready = 1'b1;
    drain(20);

    // Reset in the middle of a channel 2 packet.
    clear_all();
    drive();
    bus.mode = MODE_RR;
    push_src(2, 8'h2A, 1'b0);
    push_src(2, 8'h2B, 1'b0);
    push_src(2, 8'h2C, 1'b1);
    drive();
    #2;
    check_value("rr_ch2", 32'(bus.in_ready), 32'h4);
    push_exp(8'h2A, 1'b0, 2'd2);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_value("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check_value("rst_mid_ready", 32'(bus.in_ready),  32'h0);
    check_value("rst_mid_drop",  32'(exp_q.size()),  32'd0);
    exp_q.delete();
    clear_all();
    push_src(0, 8'h0F, 1'b1);
    push_src(2, 8'h2F, 1'b1);
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_value("rst_restart_ch0", 32'(bus.in_ready), 32'h1);
    push_exp(8'h0F, 1'b1, 2'd0);
    push_exp(8'h2F, 1'b1, 2'd2);
    drain(20);

    // Three-input instance: sel=3 is out of range and must not grant.
    check_value("n3_oob_ready", 32'(bus3.in_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_value("n3_oob_valid", 32'(bus3.out_valid), 32'd0);
    bus3.sel = 2'd2;
    #1;
    check_value("n3_sel2_ready", 32'(bus3.in_ready), 32'h4);
    @(posedge clk);
    #1;
    check_value("n3_sel2_data", 32'(bus3.out_data), 32'h33);
    check_value("n3_sel2_chan", 32'(bus3.out_chan), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
